// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, major opcodes, the canonical
// NOP encoding and the {instr, pc} pair that travels from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage : riscv_pkg

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read channel plus the
// valid/ready hand-off of {instr, instr_pc} to decode.
interface instr_fetch_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;

  // The fetch unit is the master of both channels.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready
  );

  // Memory and decode together form the slave side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready
  );

endinterface : instr_fetch_if

// File: rtl/fetch_fifo.sv
// First-word-fall-through buffer of fetched {instr, pc} pairs with a
// synchronous flush and an occupancy count used for request reservation.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments only, so every flop in
  // the design samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count alone says which
  // slots hold live data, which lets the array map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The request reservation upstream must make this impossible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow_a: assert (!(do_push && full && !do_pop));
    end
  end

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// Instruction fetch stage: in-order word requests, response tagging with PC,
// FWFT hand-off to decode, and redirect flushing of fetched and in-flight words.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  instr_fetch_if.master   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [OW-1:0]   occupancy;
  logic            started;

  logic            pop;
  logic            rsp_valid;
  logic            rsp_drop;
  logic            rsp_push;
  logic            req;
  logic            req_fire;

  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            fifo_empty;

  assign target_pc  = redirect_pc & ~XLEN'(3);
  assign push_entry = '{instr: bus.imem_rdata, pc: resp_pc};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave one holding its old value and infer a latch.
    pop       = 1'b0;
    rsp_valid = 1'b0;
    rsp_drop  = 1'b0;
    rsp_push  = 1'b0;
    req       = 1'b0;
    occupancy = '0;

    // Redirect wins over a same-cycle pop: the word being consumed is stale.
    pop = bus.instr_valid && bus.instr_ready && !redirect_valid;

    // With nothing outstanding a response cannot be ours (e.g. left over from
    // before a reset), so it is ignored outright.
    rsp_valid = bus.imem_rvalid && (outstanding != '0);
    rsp_drop  = rsp_valid && (redirect_valid || (drop_cnt != '0));
    rsp_push  = rsp_valid && !rsp_drop;

    // Slots are reserved at request time; a same-cycle pop frees one, which is
    // what sustains one word per cycle with a two-entry buffer.
    occupancy = OW'(outstanding) + OW'(fifo_count) - OW'(pop);
    req       = started && !redirect_valid && (occupancy < OW'(DEPTH));
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign req_fire      = req && bus.imem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      started     <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        // outstanding already includes words still owed to an earlier redirect,
        // so after this cycle's response every remaining one is stale.
        drop_cnt <= outstanding - CW'(rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_push) resp_pc  <= resp_pc + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Decode sees zeros rather than stale buffer contents while nothing is valid.
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? '0 : head.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      outstanding_a: assert (outstanding <= CW'(DEPTH));
      drop_a:        assert (drop_cnt <= outstanding);
      aligned_a:     assert (fetch_pc[1:0] == 2'b00 || !req);
    end
  end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Randomised bench for instr_fetch: an in-order memory with random latency and
// a transaction-level scoreboard of the expected PC stream across redirects.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int W = 32;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_pc = '0;

  instr_fetch_if #(.XLEN(W)) bus ();

  instr_fetch #(
    .XLEN     (W),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    int           due;
    int           epoch;
  } mreq_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model and scoreboard state.
  mreq_t        mq[$];
  logic [W-1:0] seen[$];
  int           cyc = 0;
  int           last_due = 0;
  int           epoch = 0;
  int           held = 0;
  int           dut_pops = 0;
  int           lat_lo = 1;
  int           lat_hi = 1;
  int           ready_pct = 100;
  int           take_pct = 100;
  logic [W-1:0] exp_pc = '0;
  logic [W-1:0] exp_req_pc = '0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // then advance the model across the rising edge.
  task automatic cycle(input logic rdr, input logic [W-1:0] tgt);
    logic         rsp_now;
    logic         fire;
    logic         popped;
    logic [W-1:0] req_addr;
    mreq_t        r;
    int           d;

    redirect_valid  = rdr;
    redirect_pc     = tgt;
    bus.imem_ready  = ($urandom_range(99) < ready_pct);
    bus.instr_ready = ($urandom_range(99) < take_pct);
    rsp_now         = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_rvalid = rsp_now;
    bus.imem_rdata  = rsp_now ? mem_word(mq[0].addr) : $urandom;
    #1;

    check("instr_valid", {31'b0, bus.instr_valid}, {31'b0, held != 0});
    if (held != 0) begin
      check("instr_pc", bus.instr_pc, exp_pc);
      check("instr", bus.instr, mem_word(exp_pc));
    end else begin
      check("idle_instr_pc", bus.instr_pc, '0);
      check("idle_instr", bus.instr, '0);
    end
    if (rdr)
      check("req_on_redirect", {31'b0, bus.imem_req}, '0);
    else if ((held + mq.size() >= D) && !((held != 0) && bus.instr_ready))
      check("req_reserved", {31'b0, bus.imem_req}, '0);
    if (bus.imem_req) check("imem_addr", bus.imem_addr, exp_req_pc);

    fire     = bus.imem_req && bus.imem_ready;
    req_addr = bus.imem_addr;
    popped   = !rdr && (held != 0) && bus.instr_ready;
    if (!rdr && bus.instr_valid && bus.instr_ready) begin
      seen.push_back(bus.instr_pc);
      dut_pops++;
    end

    @(posedge clk);
    if (rsp_now) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !rdr) held++;
    end
    if (popped) begin
      held--;
      exp_pc += 4;
    end
    if (rdr) begin
      epoch++;
      held       = 0;
      exp_pc     = {tgt[W-1:2], 2'b00};
      exp_req_pc = {tgt[W-1:2], 2'b00};
    end
    if (fire) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: req_addr, due: d, epoch: epoch});
      exp_req_pc += 4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  // Holds reset for n edges, then releases it with a stray response in the
  // first free cycle, which must be ignored.
  task automatic reset_phase(input int n);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.imem_ready  = 1'b1;
      bus.instr_ready = 1'b1;
      bus.imem_rvalid = $urandom_range(1);
      bus.imem_rdata  = $urandom;
      @(posedge clk);
      #1;
      check("rst_imem_req", {31'b0, bus.imem_req}, '0);
      check("rst_instr_valid", {31'b0, bus.instr_valid}, '0);
      check("rst_instr", bus.instr, '0);
      check("rst_instr_pc", bus.instr_pc, '0);
      @(negedge clk);
      cyc++;
    end
    mq.delete();
    epoch++;
    held       = 0;
    exp_pc     = '0;
    exp_req_pc = '0;
    last_due   = cyc;
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("post_rst_req", {31'b0, bus.imem_req}, '0);
    check("post_rst_valid", {31'b0, bus.instr_valid}, '0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bus.imem_rvalid = 1'b0;
    #1;
    check("first_req", {31'b0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
  endtask

  initial begin
    int p0;

    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    reset_phase(3);

    // Streaming, latency 1: one word per cycle once warmed up.
    run(10);
    p0 = dut_pops;
    run(30);
    check("throughput", dut_pops - p0, 30);

    // Backpressure: buffer fills to DEPTH and requests stop.
    take_pct = 0;
    run(10);
    bus.instr_ready = 1'b0;
    #1;
    check("bp_req_stopped", {31'b0, bus.imem_req}, '0);
    check("bp_valid_held", {31'b0, bus.instr_valid}, 32'd1);
    ready_pct = 0;
    take_pct  = 100;
    p0 = dut_pops;
    run(6);
    check("bp_drain_count", dut_pops - p0, D);
    ready_pct = 100;
    run(8);

    // Redirect with two requests in flight.
    lat_lo = 2;
    lat_hi = 2;
    for (int i = 0; i < 20 && mq.size() < 2; i++) cycle(1'b0, '0);
    check("inflight_two", mq.size(), 2);
    cycle(1'b1, 32'h100);
    seen.delete();
    run(12);
    check("rdr_first_pc", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h100);
    check("rdr_second_pc", (seen.size() > 1) ? seen[1] : 32'hFFFF_FFFF, 32'h104);

    // Redirect coinciding with a response and a pop; unaligned target.
    lat_lo = 1;
    lat_hi = 1;
    for (int i = 0; i < 20 && !(mq.size() > 0 && mq[0].due <= cyc && held > 0); i++)
      cycle(1'b0, '0);
    check("coincide_setup", {31'b0, mq.size() > 0 && held > 0}, 32'd1);
    cycle(1'b1, 32'h203);
    seen.delete();
    run(8);
    check("unaligned_target", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h200);

    // Back-to-back redirects: only the last target survives.
    cycle(1'b1, 32'h300);
    cycle(1'b1, 32'h400);
    seen.delete();
    run(8);
    check("b2b_redirect", (seen.size() > 0) ? seen[0] : 32'hFFFF_FFFF, 32'h400);

    // Wrap-around of the PC.
    cycle(1'b1, 32'hFFFF_FFFC);
    seen.delete();
    run(8);
    check("wrap_pc0", (seen.size() > 0) ? seen[0] : 32'h1, 32'hFFFF_FFFC);
    check("wrap_pc1", (seen.size() > 1) ? seen[1] : 32'h1, 32'h0);

    // Reset in the middle of a stream.
    reset_phase(2);
    run(10);

    // Random traffic: variable latency, stalls and redirects.
    lat_lo    = 1;
    lat_hi    = 3;
    ready_pct = 70;
    take_pct  = 70;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 4) begin
        logic [W-1:0] t;
        t = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | W'($urandom_range(15)))
                                     : W'($urandom_range(32'h0FFF));
        cycle(1'b1, t);
      end else begin
        cycle(1'b0, '0);
      end
    end
    ready_pct = 100;
    take_pct  = 100;
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_instr_fetch
